// File: rtl/watch_pkg.sv
// Shared state enum, BCD digit type and wrap constants for prog_watch.
// The alarm-setting states exist only when PROG_WATCH_ALARM_EN is defined.
package watch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_SET_HR,
    ST_SET_MIN
`ifdef PROG_WATCH_ALARM_EN
    , ST_SET_AL_HR
    , ST_SET_AL_MIN
`endif
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] MIN_WRAP  = 8'h59;
  localparam logic [7:0] HR24_WRAP = 8'h23;
  localparam logic [7:0] HR12_WRAP = 8'h12;

  // Two-digit BCD increment that jumps to wrap_to after reaching top.
  function automatic logic [7:0] bcd2_step(input logic [7:0] v, input logic [7:0] top,
                                           input logic [7:0] wrap_to);
    if (v == top) return wrap_to;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] hr_step(input logic [7:0] h, input logic mode24);
    return mode24 ? bcd2_step(h, HR24_WRAP, 8'h00) : bcd2_step(h, HR12_WRAP, 8'h01);
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit counting 0..MOD-1 with clear, load and carry-out.
module bcd_digit_counter #(
  parameter int         MOD     = 10,
  parameter logic [3:0] RST_VAL = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       inc,
  output logic [3:0] value,
  output logic       carry
);

  assign carry = inc && (value == 4'(MOD - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     value <= RST_VAL;
    else if (clear) value <= '0;
    else if (load)  value <= load_val;
    else if (inc)   value <= carry ? 4'd0 : value + 4'd1;
  end

endmodule

// File: rtl/prog_watch.sv
// Programmable BCD watch: run/pause/set FSM, minute prescaler, 12h/24h display.
// Alarm registers and alarm-setting states are compiled in by PROG_WATCH_ALARM_EN.
//   state         | meaning
//   ST_IDLE       | after reset, clock stopped
//   ST_RUN        | prescaler counting, minute ticks advance time
//   ST_PAUSE      | stopped, prescaler held
//   ST_SET_HR     | field_inc advances hour
//   ST_SET_MIN    | field_inc advances minute (no hour carry)
//   ST_SET_AL_HR  | field_inc advances alarm hour
//   ST_SET_AL_MIN | field_inc advances alarm minute
module prog_watch #(
  parameter int TICK_DIV = 60,
  parameter int MODE24   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_resume,
  input  logic       stop,
  input  logic       set_time,
  input  logic       field_inc,
  input  logic       set_alarm,
  output logic [3:0] hr1,
  output logic [3:0] hr0,
  output logic [3:0] min1,
  output logic [3:0] min0,
  output logic       pm,
  output logic       daypass,
  output logic       running,
  output logic       alarm
);
  import watch_pkg::*;

  localparam int PW  = $clog2(TICK_DIV);
  localparam bit M24 = (MODE24 != 0);

  state_t        state, state_nxt;
  logic [PW-1:0] presc;
  logic          tick, in_set, min_step, hour_step, hr_wrap, hr_clr;
  logic          min0_c, min1_c, hr0_c, unused_hr1_c;
  logic [7:0]    cur_hr, cur_min;

  assign cur_hr    = {hr1, hr0};
  assign cur_min   = {min1, min0};
  assign tick      = (state == ST_RUN) && (presc == PW'(TICK_DIV - 1));
  assign min_step  = tick || (state == ST_SET_MIN && field_inc);
  assign hour_step = (tick && min1_c) || (state == ST_SET_HR && field_inc);
  assign hr_wrap   = (cur_hr == (M24 ? HR24_WRAP : HR12_WRAP));
  assign hr_clr    = hour_step && hr_wrap;

`ifdef PROG_WATCH_ALARM_EN
  assign in_set = state inside {ST_SET_HR, ST_SET_MIN, ST_SET_AL_HR, ST_SET_AL_MIN};
`else
  assign in_set = state inside {ST_SET_HR, ST_SET_MIN};
`endif

  bcd_digit_counter #(.MOD(10), .RST_VAL(4'd0)) u_min0 (
    .clk(clk), .reset(reset), .clear(1'b0), .load(1'b0), .load_val(4'd0),
    .inc(min_step), .value(min0), .carry(min0_c));

  bcd_digit_counter #(.MOD(6), .RST_VAL(4'd0)) u_min1 (
    .clk(clk), .reset(reset), .clear(1'b0), .load(1'b0), .load_val(4'd0),
    .inc(min0_c), .value(min1), .carry(min1_c));

  // 24h wraps 23 -> 00 by clearing; 12h wraps 12 -> 01 by loading the units digit.
  bcd_digit_counter #(.MOD(10), .RST_VAL(M24 ? 4'd0 : 4'd2)) u_hr0 (
    .clk(clk), .reset(reset), .clear(hr_clr && M24), .load(hr_clr && !M24), .load_val(4'd1),
    .inc(hour_step && !hr_wrap), .value(hr0), .carry(hr0_c));

  bcd_digit_counter #(.MOD(M24 ? 3 : 2), .RST_VAL(M24 ? 4'd0 : 4'd1)) u_hr1 (
    .clk(clk), .reset(reset), .clear(hr_clr), .load(1'b0), .load_val(4'd0),
    .inc(hr0_c), .value(hr1), .carry(unused_hr1_c));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_PAUSE: begin
        if (start_resume && !stop) state_nxt = ST_RUN;
        else if (set_time)         state_nxt = ST_SET_HR;
`ifdef PROG_WATCH_ALARM_EN
        else if (set_alarm)        state_nxt = ST_SET_AL_HR;
`endif
      end
      ST_RUN:     if (stop)     state_nxt = ST_PAUSE;
      ST_SET_HR:  if (set_time) state_nxt = ST_SET_MIN;
      ST_SET_MIN: if (set_time) state_nxt = ST_PAUSE;
`ifdef PROG_WATCH_ALARM_EN
      ST_SET_AL_HR:  if (set_alarm) state_nxt = ST_SET_AL_MIN;
      ST_SET_AL_MIN: if (set_alarm) state_nxt = ST_PAUSE;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      presc   <= '0;
      running <= 1'b0;
      daypass <= 1'b0;
      pm      <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == ST_RUN);
      if (in_set)               presc <= '0;
      else if (state == ST_RUN) presc <= tick ? '0 : presc + PW'(1);
      daypass <= tick && min1_c && (M24 ? hr_wrap : (pm && cur_hr == 8'h11));
      if (!M24 && hour_step && cur_hr == 8'h11) pm <= !pm;
    end
  end

`ifdef PROG_WATCH_ALARM_EN
  logic [7:0] al_hr, al_min, nxt_hr, nxt_min;
  logic       al_pm, nxt_pm;

  // Time the current tick is about to produce, so the alarm lines up with the display.
  always_comb begin
    nxt_min = bcd2_step(cur_min, MIN_WRAP, 8'h00);
    nxt_hr  = cur_hr;
    nxt_pm  = pm;
    if (cur_min == MIN_WRAP) begin
      nxt_hr = hr_step(cur_hr, M24);
      nxt_pm = pm ^ (!M24 && cur_hr == 8'h11);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      al_hr  <= M24 ? 8'h00 : 8'h12;
      al_min <= 8'h00;
      al_pm  <= 1'b0;
      alarm  <= 1'b0;
    end else begin
      alarm <= tick && ({nxt_hr, nxt_min, nxt_pm} == {al_hr, al_min, al_pm});
      if (state == ST_SET_AL_HR && field_inc) begin
        al_hr <= hr_step(al_hr, M24);
        if (!M24 && al_hr == 8'h11) al_pm <= !al_pm;
      end
      if (state == ST_SET_AL_MIN && field_inc) al_min <= bcd2_step(al_min, MIN_WRAP, 8'h00);
    end
  end
`else
  logic unused_set_alarm;
  assign unused_set_alarm = set_alarm;
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_prog_watch.sv
// Scoreboard bench for prog_watch: one 24h and one 12h instance share stimulus;
// the reference keeps time as minutes-of-day and derives each display from it.
module tb_prog_watch;
  localparam int TDIV = 4;
`ifdef PROG_WATCH_ALARM_EN
  localparam bit HAS_ALARM = 1'b1;
`else
  localparam bit HAS_ALARM = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_resume = 1'b0, stop = 1'b0, set_time = 1'b0, field_inc = 1'b0, set_alarm = 1'b0;
  logic [3:0] hr1_a, hr0_a, min1_a, min0_a, hr1_b, hr0_b, min1_b, min0_b;
  logic pm_a, daypass_a, running_a, alarm_a, pm_b, daypass_b, running_b, alarm_b;

  always #5 clk = ~clk;

  prog_watch #(.TICK_DIV(TDIV), .MODE24(1)) dut_a (
    .clk(clk), .reset(reset), .start_resume(start_resume), .stop(stop),
    .set_time(set_time), .field_inc(field_inc), .set_alarm(set_alarm),
    .hr1(hr1_a), .hr0(hr0_a), .min1(min1_a), .min0(min0_a),
    .pm(pm_a), .daypass(daypass_a), .running(running_a), .alarm(alarm_a));

  prog_watch #(.TICK_DIV(TDIV), .MODE24(0)) dut_b (
    .clk(clk), .reset(reset), .start_resume(start_resume), .stop(stop),
    .set_time(set_time), .field_inc(field_inc), .set_alarm(set_alarm),
    .hr1(hr1_b), .hr0(hr0_b), .min1(min1_b), .min0(min0_b),
    .pm(pm_b), .daypass(daypass_b), .running(running_b), .alarm(alarm_b));

  typedef struct {
    logic [19:0] a;
    logic [19:0] b;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  string m_mode = "IDLE";
  int    m_mins = 0;
  int    m_alm  = 0;
  int    m_left = TDIV;
  bit    m_dp   = 1'b0;
  bit    m_al   = 1'b0;

  function automatic logic [19:0] act_a();
    return {hr1_a, hr0_a, min1_a, min0_a, pm_a, daypass_a, running_a, alarm_a};
  endfunction

  function automatic logic [19:0] act_b();
    return {hr1_b, hr0_b, min1_b, min0_b, pm_b, daypass_b, running_b, alarm_b};
  endfunction

  function automatic logic [19:0] disp(input int mins, input bit m24, input bit dp,
                                       input bit run, input bit al);
    int h, mm;
    bit p;
    h  = mins / 60;
    mm = mins % 60;
    p  = 1'b0;
    if (!m24) begin
      p = (h >= 12);
      h = h % 12;
      if (h == 0) h = 12;
    end
    return {4'(h / 10), 4'(h % 10), 4'(mm / 10), 4'(mm % 10), p, dp, run, al};
  endfunction

  function automatic string fmt(input logic [19:0] v);
    return $sformatf("%h%h:%h%h pm=%b dp=%b run=%b al=%b",
                     v[19:16], v[15:12], v[11:8], v[7:4], v[3], v[2], v[1], v[0]);
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %s, want %s", name, fmt(act), fmt(exp));
    end
  endtask

  function automatic int bump_min(input int mins);
    return mins - (mins % 60) + ((mins % 60) + 1) % 60;
  endfunction

  task automatic model_step(input bit st, input bit sp, input bit stt, input bit fi, input bit sa);
    m_dp = 1'b0;
    m_al = 1'b0;
    if (m_mode == "RUN") begin
      m_left--;
      if (m_left == 0) begin
        m_left = TDIV;
        m_mins = (m_mins + 1) % 1440;
        m_dp   = (m_mins == 0);
        m_al   = HAS_ALARM && (m_mins == m_alm);
      end
      if (sp) m_mode = "PAUSE";
    end else if (m_mode == "IDLE" || m_mode == "PAUSE") begin
      if (st && !sp)            m_mode = "RUN";
      else if (stt)             m_mode = "SET_HR";
      else if (HAS_ALARM && sa) m_mode = "AL_HR";
    end else if (m_mode == "SET_HR") begin
      if (fi)  m_mins = (m_mins + 60) % 1440;
      if (stt) m_mode = "SET_MIN";
    end else if (m_mode == "SET_MIN") begin
      if (fi) m_mins = bump_min(m_mins);
      if (stt) begin m_mode = "PAUSE"; m_left = TDIV; end
    end else if (m_mode == "AL_HR") begin
      if (fi) m_alm = (m_alm + 60) % 1440;
      if (sa) m_mode = "AL_MIN";
    end else if (m_mode == "AL_MIN") begin
      if (fi) m_alm = bump_min(m_alm);
      if (sa) begin m_mode = "PAUSE"; m_left = TDIV; end
    end
  endtask

  // Called on a falling edge: drive one cycle of commands and queue the expected outputs.
  task automatic drive(input bit st, input bit sp, input bit stt, input bit fi, input bit sa);
    exp_t e;
    start_resume = st; stop = sp; set_time = stt; field_inc = fi; set_alarm = sa;
    model_step(st, sp, stt, fi, sa);
    e.a = disp(m_mins, 1'b1, m_dp, m_mode == "RUN", m_al);
    e.b = disp(m_mins, 1'b0, m_dp, m_mode == "RUN", m_al);
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input string tag);
    start_resume = 0; stop = 0; set_time = 0; field_inc = 0; set_alarm = 0;
    reset  = 1'b0;
    m_mode = "IDLE"; m_mins = 0; m_alm = 0; m_left = TDIV; m_dp = 0; m_al = 0;
    #1;
    check({tag, " 24h"}, act_a(), disp(0, 1'b1, 1'b0, 1'b0, 1'b0));
    check({tag, " 12h"}, act_b(), disp(0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Requires IDLE or PAUSE; walks SET_HR and SET_MIN to reach h:m (24h terms).
  task automatic set_time_to(input int h, input int m);
    int nh, nm;
    drive(0, 0, 1, 0, 0);
    nh = (h - m_mins / 60 + 24) % 24;
    repeat (nh) drive(0, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 0);
    nm = (m - m_mins % 60 + 60) % 60;
    repeat (nm) drive(0, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("cyc%0d 24h", cyc), act_a(), e.a);
        check($sformatf("cyc%0d 12h", cyc), act_b(), e.b);
      end
    end
  end

  initial begin : stimulus
    int r, nm;
    @(negedge clk);
    do_reset("reset");

    // free run from 00:00: one minute per TDIV cycles, 01:00 after 240 cycles
    drive(1, 0, 0, 0, 0);
    idle(240);

    // stop and start together while running: pause wins, prescaler kept
    idle(1);
    drive(1, 1, 0, 0, 0);
    idle(3);
    drive(1, 0, 0, 0, 0);
    idle(6);
    drive(0, 1, 0, 0, 0);

    // day rollover 23:59 -> 00:00 (12h: 11:59pm -> 12:00am)
    set_time_to(23, 59);
    drive(1, 0, 0, 0, 0);
    idle(TDIV + 1);
    drive(0, 1, 0, 0, 0);

    // 12:59pm -> 01:00pm and 12:59am -> 01:00am, no daypass
    set_time_to(12, 59);
    drive(1, 0, 0, 0, 0);
    idle(TDIV + 1);
    drive(0, 1, 0, 0, 0);
    set_time_to(0, 59);
    drive(1, 0, 0, 0, 0);
    idle(TDIV + 1);
    drive(0, 1, 0, 0, 0);

    // reset while editing minutes at 37
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    nm = (37 - m_mins % 60 + 60) % 60;
    repeat (nm) drive(0, 0, 0, 1, 0);
    do_reset("reset in SET_MIN");

    // alarm at 00:02, run from 00:00
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    idle(3 * TDIV + 2);
    drive(0, 1, 0, 0, 0);

    // randomized command stream
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 5)       drive(1, 0, 0, 0, 0);
      else if (r < 8)  drive(0, 1, 0, 0, 0);
      else if (r < 11) drive(0, 0, 1, 0, 0);
      else if (r < 13) drive(0, 0, 0, 0, 1);
      else if (r < 30) drive(0, 0, 0, 1, 0);
      else if (r < 32) drive(1, 1, 0, 0, 0);
      else             drive(0, 0, 0, 0, 0);
      if ($urandom_range(0, 799) == 0) do_reset("random reset");
    end

    start_resume = 0; stop = 0; set_time = 0; field_inc = 0; set_alarm = 0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_watch.md
PROG_WATCH -- requirements
Module: prog_watch

Interface
REQ-001 Parameter TICK_DIV, default 60, clk cycles per minute tick (>=2).
REQ-002 Parameter MODE24, default 0; 0 = 12-hour display (12,01..11 + pm), 1 = 24-hour display (00..23).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start_resume, stop, set_time, field_inc, set_alarm  input  1 each  single-cycle command pulses.
REQ-006 hr1, hr0, min1, min0  output  4 each  BCD time digits.
REQ-007 pm  output  1  afternoon flag; constant 0 when MODE24=1.
REQ-008 daypass  output  1  one-cycle pulse on day rollover.
REQ-009 running  output  1  high only in RUN state.
REQ-010 alarm  output  1  one-cycle alarm pulse (see Configuration).

Function
REQ-011 FSM states: IDLE, RUN, PAUSE, SET_HR, SET_MIN (+ SET_AL_HR, SET_AL_MIN when alarm compiled in).
REQ-012 IDLE/PAUSE + start_resume -> RUN; RUN + stop -> PAUSE; stop wins over simultaneous start_resume.
REQ-013 IDLE/PAUSE + set_time -> SET_HR -> (set_time) SET_MIN -> (set_time) PAUSE; set_time in RUN ignored.
REQ-014 Prescaler counts 0..TICK_DIV-1 only in RUN; minute tick when prescaler = TICK_DIV-1, prescaler then returns to 0.
REQ-015 Prescaler holds in PAUSE, clears to 0 on any exit from a SET state.
REQ-016 Minute tick: min 59 -> 00 with hour carry; otherwise min+1, hour unchanged; outputs update the cycle after the tick.
REQ-017 24h hour carry: 23 -> 00 asserts daypass; else hour+1.
REQ-018 12h hour carry: 11 -> 12 toggles pm; 12 -> 01; daypass asserted when pm toggles 1 -> 0 (11:59pm -> 12:00am).
REQ-019 field_inc in SET_HR: hour+1 using REQ-017/018 wrap, pm toggles as in REQ-018, no daypass; in SET_MIN: 59 -> 00, no hour carry.
REQ-020 field_inc outside SET states ignored; command pulses in the same cycle as state transition act on the old state only.
REQ-021 Digits always legal BCD; min1 <= 5, hr1 <= 2 (24h) or <= 1 (12h).

Reset
REQ-022 reset low: state IDLE, prescaler 0, time 00:00 (MODE24=1) or 12:00 pm=0 (MODE24=0), daypass/alarm/running 0.
REQ-023 reset asserted mid-RUN or mid-SET aborts immediately; no pulse output generated on release.

Configuration
REQ-024 Macro PROG_WATCH_ALARM_EN compiles in alarm registers (hour, minute, 12h pm) reset to the reset time value.
REQ-025 With macro: set_alarm in IDLE/PAUSE -> SET_AL_HR -> (set_alarm) SET_AL_MIN -> (set_alarm) PAUSE; field_inc edits alarm fields per REQ-019.
REQ-026 With macro: alarm pulses one cycle when a RUN minute tick produces time equal to alarm time (incl. pm).
REQ-027 Without macro: ports unchanged, set_alarm ignored, alarm tied 0, SET_AL states absent.

Structure
REQ-028 Package watch_pkg holds the FSM state enum, BCD digit typedef and wrap constants (59, 23, 12).
REQ-029 Sub-module bcd_digit_counter: parametrised modulus digit counter with inc, clear, carry-out; instanced per digit.

Verification
REQ-030 TICK_DIV=4, MODE24=1, start at 00:00: 240 RUN cycles -> 01:00, minute steps every 4 cycles.
REQ-031 MODE24=1, set 23:59 via set_time/field_inc, run 1 tick -> 00:00, daypass high exactly 1 cycle.
REQ-032 MODE24=0, set 11:59 pm=1, run 1 tick -> 12:00 pm=0, daypass 1 cycle; 12:59 -> 01:00 no daypass.
REQ-033 stop+start_resume same cycle in RUN -> PAUSE; prescaler retained, resume ticks after remaining cycles.
REQ-034 reset low mid SET_MIN with min=37 -> IDLE, 12:00 (12h), all pulses 0.
REQ-035 ALARM_EN, alarm 00:02, run from 00:00 -> alarm pulses once at 00:02 tick; macro off -> alarm stays 0.
